// File: rtl/stage_seq_if.sv
// stage_seq_if: control inputs and phase-strobe outputs of the stage sequencer.
// Revision 1.0
`default_nettype none

interface stage_seq_if #(
    parameter int NUM_PHASES = 8,
    parameter int PHASE_W    = 3,
    parameter int CNT_W      = 16
);
    logic                  run;
    logic                  stall;
    logic                  step_mode;
    logic                  step_req;
    logic [PHASE_W-1:0]    phase;
    logic [NUM_PHASES-1:0] phase_strobe;
    logic                  fetch_en;
    logic                  decode_en;
    logic                  read_en;
    logic                  wb_en;
    logic                  cycle_done;
    logic                  busy;
    logic [CNT_W-1:0]      instr_count;

    modport master (
        output run, stall, step_mode, step_req,
        input  phase, phase_strobe, fetch_en, decode_en, read_en, wb_en,
               cycle_done, busy, instr_count
    );

    modport slave (
        input  run, stall, step_mode, step_req,
        output phase, phase_strobe, fetch_en, decode_en, read_en, wb_en,
               cycle_done, busy, instr_count
    );
endinterface

`default_nettype wire

// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot phase strobe engine with stall, graceful stop and instruction counter.
// Optional single-step mode enabled by `define STAGE_SEQ_SINGLE_STEP_EN. Revision 1.0
`default_nettype none

module stage_sequencer #(
    parameter int NUM_PHASES   = 8,
    parameter int PHASE_W      = 3,
    parameter int CNT_W        = 16,
    parameter int FETCH_PHASE  = 0,
    parameter int DECODE_PHASE = 2,
    parameter int READ_PHASE   = 3,
    parameter int WB_PHASE     = 7
) (
    input  wire logic   clk,
    input  wire logic   reset,
    stage_seq_if.slave  bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_STALL = 2'd2;
    localparam logic [1:0] c_STEP  = 2'd3;

    localparam logic [PHASE_W-1:0]    c_LAST = PHASE_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] c_ONE  = {{(NUM_PHASES-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [1:0]            ret_q, ret_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [NUM_PHASES-1:0] strobe_q, strobe_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  w_at_last;
    logic                  w_issue;

    assign w_at_last = (phase_q == c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_IDLE;
            ret_q    <= c_RUN;
            phase_q  <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            c_IDLE: begin
`ifdef STAGE_SEQ_SINGLE_STEP_EN
                if (!bus.stall && bus.step_mode && bus.step_req) begin
                    state_d = c_STEP;
                end else if (!bus.stall && !bus.step_mode && bus.run) begin
                    state_d = c_RUN;
                end
`else
                if (!bus.stall && bus.run) begin
                    state_d = c_RUN;
                end
`endif
            end
`ifdef STAGE_SEQ_SINGLE_STEP_EN
            c_RUN, c_STEP: begin
`else
            c_RUN: begin
`endif
                if (bus.stall) begin
                    state_d = c_STALL;
                    ret_d   = state_q;
                end else if (w_at_last && (state_q == c_STEP || !bus.run)) begin
                    state_d = c_IDLE;
                end
            end
            c_STALL: begin
                // A held last phase was already retired, so release starts a new cycle or stops.
                if (!bus.stall) begin
                    if (!w_at_last) begin
                        state_d = ret_q;
                    end else if (ret_q == c_RUN && bus.run) begin
                        state_d = c_RUN;
                    end else begin
                        state_d = c_IDLE;
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_issue = (state_d == c_RUN) || (state_d == c_STEP);
        phase_d = phase_q;
        count_d = count_q;
        if ((state_q == c_RUN || state_q == c_STEP) && w_at_last) begin
            count_d = count_q + 1'b1;
        end
        if (state_d == c_IDLE) begin
            phase_d = '0;
        end else if (w_issue) begin
            if (state_q == c_IDLE || w_at_last) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        strobe_d = w_issue ? (c_ONE << phase_d) : '0;
        done_d   = w_issue && (phase_d == c_LAST);
        busy_d   = (state_d != c_IDLE);
    end

`ifndef STAGE_SEQ_SINGLE_STEP_EN
    logic w_unused_step;
    assign w_unused_step = bus.step_mode ^ bus.step_req;
`endif

    assign bus.phase        = phase_q;
    assign bus.phase_strobe = strobe_q;
    assign bus.fetch_en     = strobe_q[FETCH_PHASE];
    assign bus.decode_en    = strobe_q[DECODE_PHASE];
    assign bus.read_en      = strobe_q[READ_PHASE];
    assign bus.wb_en        = strobe_q[WB_PHASE];
    assign bus.cycle_done   = done_q;
    assign bus.busy         = busy_q;
    assign bus.instr_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of strobes, stop, stall, async reset, step mode and count wrap.
// Revision 1.0
`default_nettype none

module tb_stage_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    stage_seq_if #(.NUM_PHASES(8), .PHASE_W(3), .CNT_W(16)) u_if ();
    stage_seq_if #(.NUM_PHASES(8), .PHASE_W(3), .CNT_W(4))  u_if4 ();

    stage_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    stage_sequencer #(.CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one issuing cycle at phase p with the given instruction count.
    task automatic chk_phase(input string tag, input int p, input int cnt);
        chk({tag, ".phase"},  32'(u_if.phase), 32'(p));
        chk({tag, ".strobe"}, 32'(u_if.phase_strobe), 32'(1) << p);
        chk({tag, ".done"},   32'(u_if.cycle_done), 32'(p == 7));
        chk({tag, ".en"},     {28'd0, u_if.fetch_en, u_if.decode_en, u_if.read_en, u_if.wb_en},
                              {28'd0, p == 0, p == 2, p == 3, p == 7});
        chk({tag, ".busy"},   32'(u_if.busy), 32'd1);
        chk({tag, ".count"},  32'(u_if.instr_count), 32'(cnt));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        u_if.run = 1'b0;  u_if.stall = 1'b0;  u_if.step_mode = 1'b0;  u_if.step_req = 1'b0;
        u_if4.run = 1'b0; u_if4.stall = 1'b0; u_if4.step_mode = 1'b0; u_if4.step_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst.phase",  32'(u_if.phase), 32'd0);
        chk("rst.strobe", 32'(u_if.phase_strobe), 32'd0);
        chk("rst.busy",   32'(u_if.busy), 32'd0);
        chk("rst.done",   32'(u_if.cycle_done), 32'd0);
        chk("rst.count",  32'(u_if.instr_count), 32'd0);

        // Continuous run: three full cycles then the start of the fourth.
        u_if.run = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            chk_phase("run", i % 8, i / 8);
        end

        // Drop run at phase 3: remaining phases complete, then idle.
        for (int i = 1; i <= 3; i++) tick();
        chk_phase("drop.p3", 3, 3);
        u_if.run = 1'b0;
        for (int p = 4; p < 8; p++) begin
            tick();
            chk_phase("drop", p, 3);
        end
        tick();
        chk("drop.busy",   32'(u_if.busy), 32'd0);
        chk("drop.strobe", 32'(u_if.phase_strobe), 32'd0);
        chk("drop.phase",  32'(u_if.phase), 32'd0);
        chk("drop.count",  32'(u_if.instr_count), 32'd4);

        // Stall for five clocks at phase 2.
        u_if.run = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk_phase("stl.pre", p, 4);
        end
        u_if.stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stl.phase",  32'(u_if.phase), 32'd2);
            chk("stl.strobe", 32'(u_if.phase_strobe), 32'd0);
            chk("stl.busy",   32'(u_if.busy), 32'd1);
        end
        u_if.stall = 1'b0;
        u_if.run   = 1'b0;
        for (int p = 3; p < 8; p++) begin
            tick();
            chk_phase("stl.post", p, 4);
        end
        tick();
        chk("stl.idle",  32'(u_if.busy), 32'd0);
        chk("stl.count", 32'(u_if.instr_count), 32'd5);

        // Stall while idle blocks the start.
        u_if.run = 1'b1;
        u_if.stall = 1'b1;
        tick();
        tick();
        chk("idlestl.busy",   32'(u_if.busy), 32'd0);
        chk("idlestl.strobe", 32'(u_if.phase_strobe), 32'd0);
        u_if.stall = 1'b0;
        tick();
        chk_phase("idlestl.start", 0, 5);

        // Asynchronous reset at phase 5.
        for (int p = 1; p <= 5; p++) tick();
        chk_phase("arst.p5", 5, 5);
        u_if.run = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst.phase",  32'(u_if.phase), 32'd0);
        chk("arst.strobe", 32'(u_if.phase_strobe), 32'd0);
        chk("arst.done",   32'(u_if.cycle_done), 32'd0);
        chk("arst.busy",   32'(u_if.busy), 32'd0);
        chk("arst.count",  32'(u_if.instr_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("arst.stay", 32'(u_if.busy), 32'd0);

`ifdef STAGE_SEQ_SINGLE_STEP_EN
        u_if.step_mode = 1'b1;
        u_if.run = 1'b1;
        tick();
        tick();
        chk("step.runblk", 32'(u_if.busy), 32'd0);
        for (int b = 0; b < 2; b++) begin
            u_if.step_req = 1'b1;
            tick();
            u_if.step_req = 1'b0;
            chk_phase("step.b", 0, b);
            for (int p = 1; p < 8; p++) begin
                if (p == 3) u_if.step_req = 1'b1;
                tick();
                u_if.step_req = 1'b0;
                chk_phase("step.b", p, b);
            end
            tick();
            chk("step.idle",  32'(u_if.busy), 32'd0);
            chk("step.count", 32'(u_if.instr_count), 32'(b + 1));
            for (int k = 0; k < 11; k++) tick();
            chk("step.quiet", 32'(u_if.phase_strobe), 32'd0);
        end
        u_if.run = 1'b0;
        u_if.step_mode = 1'b0;
`else
        u_if.step_mode = 1'b1;
        u_if.step_req = 1'b1;
        tick();
        u_if.step_req = 1'b0;
        chk("nostep.ignored", 32'(u_if.busy), 32'd0);
        u_if.run = 1'b1;
        tick();
        chk_phase("nostep.run", 0, 0);
        u_if.run = 1'b0;
        for (int p = 1; p < 8; p++) tick();
        chk_phase("nostep.p7", 7, 0);
        tick();
        chk("nostep.idle",  32'(u_if.busy), 32'd0);
        chk("nostep.count", 32'(u_if.instr_count), 32'd1);
        u_if.step_mode = 1'b0;
`endif

        // Counter wrap on the 4-bit instance.
        u_if4.run = 1'b1;
        tick();
        for (int i = 0; i < 120; i++) tick();
        chk("wrap.pre",   32'(u_if4.instr_count), 32'd15);
        chk("wrap.phase", 32'(u_if4.phase), 32'd0);
        u_if4.run = 1'b0;
        for (int p = 1; p < 8; p++) tick();
        chk("wrap.done", 32'(u_if4.cycle_done), 32'd1);
        tick();
        chk("wrap.count", 32'(u_if4.instr_count), 32'd0);
        chk("wrap.busy",  32'(u_if4.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
